// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package serial_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_ctrl_sub_nibble.sv
// 4-bit subtract slice: a + ~b + cin, carry-out is the inverted borrow.
module sub_nibble
  import serial_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] d,
  output logic                cout
);

  assign {cout, d} = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_sub_ctrl.sv
// Nibble-serial subtractor with valid/ready handshakes on both sides.
// Define SERIAL_SUB_FLAGS_EN to add the registered zero/neg/ovf outputs.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero,
  output logic             neg,
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   aOp_q, aOp_d;
  logic [WIDTH-1:0]   bOp_q, bOp_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] nibA, nibB, nibD;
  logic                nibCout;

  assign nibA = aOp_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  assign nibB = bOp_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

  // The single slice is shared across all nibbles; the carry register chains them.
  sub_nibble uSlice (
    .a    (nibA),
    .b    (nibB),
    .cin  (carry_q),
    .d    (nibD),
    .cout (nibCout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aOp_d   = a;
          bOp_d   = b;
          carry_d = ~bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = nibD;
        carry_d = nibCout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          bout_d  = ~nibCout;
          state_d = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = (diff_d == '0);
          neg_d   = nibD[NIBBLE_W-1];
          ovf_d   = (aOp_q[WIDTH-1] ^ bOp_q[WIDTH-1]) & (nibD[NIBBLE_W-1] ^ aOp_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      aOp_q   <= '0;
      bOp_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH = 16.
// Flag checks are compiled in only when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request, lets it be accepted, then scrambles the operand inputs.
  task automatic applyStimulus(input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn, input logic binIn);
    @(negedge clk);
    in_valid = 1'b1;
    a        = aIn;
    b        = bIn;
    bin      = binIn;
    checkOutput("accept_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~aIn;
    b        = WIDTH'($urandom);
    bin      = ~binIn;
    checkOutput("run_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // out_valid must stay low for NIB-1 edges after accept and rise on edge NIB.
  task automatic waitResult(input string tag);
    for (int k = 1; k <= NIB; k++) begin
      @(negedge clk);
      checkOutput({tag, "_valid_timing"}, {31'd0, out_valid}, (k == NIB) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                       input logic binIn, input logic [WIDTH-1:0] expDiff, input logic expBout,
                       input logic expZero, input logic expNeg, input logic expOvf);
    applyStimulus(aIn, bIn, binIn);
    waitResult(tag);
    checkOutput({tag, "_diff"}, {16'd0, diff}, {16'd0, expDiff});
    checkOutput({tag, "_bout"}, {31'd0, bout}, {31'd0, expBout});
`ifdef SERIAL_SUB_FLAGS_EN
    checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, expZero});
    checkOutput({tag, "_neg"},  {31'd0, neg},  {31'd0, expNeg});
    checkOutput({tag, "_ovf"},  {31'd0, ovf},  {31'd0, expOvf});
`else
    if (expZero && expNeg && expOvf) $display("[TB] note: unreachable flag combination");
`endif
    releaseResult(tag);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_diff",      {16'd0, diff},      32'd0);
    checkOutput("reset_bout",      {31'd0, bout},      32'd0);
    rst = 1'b0;

    runOp("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    runOp("ovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp("bin1",    16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    runOp("bin0",    16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    runOp("nibbles", 16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: result held in DONE while a second request is ignored.
    applyStimulus(16'h1234, 16'h0001, 1'b0);
    waitResult("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1;
        a        = 16'h0F0F;
        b        = 16'h0000;
      end
      if (i == 5) in_valid = 1'b0;
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_diff",      {16'd0, diff},      32'h1233);
      checkOutput("bp_bout",      {31'd0, bout},      32'd0);
      checkOutput("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    releaseResult("bp");
    @(negedge clk);
    checkOutput("bp_no_stale_accept", {31'd0, in_ready}, 32'd1);

    // Reset asserted during the second RUN cycle aborts the request.
    applyStimulus(16'h00FF, 16'h0F00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_diff",      {16'd0, diff},      32'd0);
    checkOutput("abort_bout",      {31'd0, bout},      32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    runOp("after_abort", 16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; a multiple of 4, minimum 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port a, input, WIDTH bits: minuend.
REQ-007 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 SHALL have port bin, input, 1 bit: borrow-in; 1 subtracts an extra 1.
REQ-009 SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout, output, 1 bit: borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-013 SHALL sequence one 4-bit subtract slice over NIB = WIDTH/4 nibbles, LSB nibble first.
REQ-014 SHALL implement the slice as a ripple adder: a_nib + ~b_nib + cin; slice carry = NOT borrow.
REQ-015 SHALL set nibble-0 cin = ~bin; each later nibble's cin = the previous nibble's carry-out; bout = ~(final carry-out).
REQ-016 SHALL use FSM states IDLE, RUN and DONE.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 SHALL accept on a clock edge where in_valid and in_ready are both 1, latch a, b and bin, clear the nibble index, and enter RUN.
REQ-019 SHALL compute one nibble per RUN cycle, write it into diff[4i+3:4i], and increment the index.
REQ-020 SHALL go to DONE on the edge that completes nibble NIB-1; out_valid SHALL rise exactly NIB edges after the accepting edge.
REQ-021 SHALL hold diff and bout stable, and out_valid at 1, in DONE until out_valid and out_ready are both 1, then return to IDLE; no accept is possible in that same cycle.
REQ-022 SHALL ignore in_valid in RUN and DONE, and SHALL ignore changes on a, b and bin after the accepting edge.
REQ-023 SHALL handle WIDTH = 4 as a single RUN cycle with identical handshake rules.
REQ-024 SHALL keep out_valid at 0 in IDLE and RUN; diff bits not yet computed SHALL be undefined to the consumer, and only values shown while out_valid = 1 are valid.

Reset
REQ-025 SHALL, while rst is 1 at a clock edge, force state to IDLE, the index to 0, diff to 0, bout to 0, out_valid to 0, in_ready to 1 after the edge, and all flags to 0.
REQ-026 SHALL abort any in-flight operation on reset, without producing out_valid; rst SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-027 SHALL, when SERIAL_SUB_FLAGS_EN is defined, add outputs zero (diff == 0), neg (diff[WIDTH-1]) and ovf (signed overflow: a and b MSBs differ and the diff MSB differs from the a MSB), each 1 bit, registered and valid with out_valid.
REQ-028 SHALL, without SERIAL_SUB_FLAGS_EN, omit the zero, neg and ovf ports and their logic; all other behaviour SHALL be unchanged.

Structure
REQ-029 SHALL place the FSM state enum (IDLE/RUN/DONE) and the NIBBLE_W = 4 constant in the shared package serial_sub_pkg.
REQ-030 SHALL instantiate one sub-module, sub_nibble, as the 4-bit combinational slice (inputs a, b, cin; outputs d, cout); it is instantiated once and time-multiplexed.

Verification (WIDTH = 16)
REQ-031 SHALL cover basic timing: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, out_valid exactly 4 edges after accept.
REQ-032 SHALL cover borrow wrap: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, neg=1, zero=0.
REQ-033 SHALL cover signed overflow: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
REQ-034 SHALL cover borrow-in: a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1; then bin=0 -> diff=0x0000, bout=0, zero=1.
REQ-035 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> diff, bout and out_valid stable, in_ready=0, a second in_valid pulse ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 SHALL cover reset mid-operation: rst pulsed during the 2nd RUN cycle -> after that edge in_ready=1, out_valid=0, diff=0, and no result is emitted for the aborted request.
